issue_stage: RTL and testbench

// - Sits directly upstream of the execute stage. Holds one decoded MicroCode entry from decode and owns the 32x32 integer register file.
// - Reads rs1/rs2 with write-back bypass and drives the execute stage with a one-cycle en pulse.
// - Holds operands stable while execute runs multi-cycle load/store operations.
// - Detects control-flow redirects from the execute stage's committed PC and flushes the wrong-path entry.

---
 rtl/issue_stage.sv | 184 ++++++++++++++++++
 tb/tb_issue_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// Issue stage: holds one decoded entry, owns the integer register file with
// write-back bypass, pulses execute and raises a redirect on a wrong-path PC.
package issue_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd;
        logic            rd_en;
        logic            alu_en;
        logic            lsu_en;
        logic            br_en;
    } microcode_t;
endpackage

module issue_stage
    import issue_pkg::*;
#(
    parameter int unsigned     NREG    = 32,
    parameter logic [XLEN-1:0] REG_RST = 32'h0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  microcode_t      i_in_microcode,
    output logic            o_exe_en,
    output microcode_t      o_exe_microcode,
    output logic [XLEN-1:0] o_exe_rs1_data,
    output logic [XLEN-1:0] o_exe_rs2_data,
    input  logic            i_exe_busy,
    input  logic            i_exe_done,
    input  logic [XLEN-1:0] i_exe_committed_pc,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    microcode_t      r_held;
    microcode_t      r_issued;
    logic [XLEN-1:0] r_regs [NREG];
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_issue;
    logic            w_done;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_mispredict;
    logic [XLEN-1:0] w_cur_pc;
    microcode_t      w_exe_mc;

    // x0 reads as zero; a same-cycle write-back to the read address wins over the array.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      addr,
        input logic            wb_en,
        input logic [4:0]      wb_addr,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] reg_val
    );
        logic [XLEN-1:0] val;
        if (addr == 5'd0) begin
            val = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == addr)) begin
            val = wb_data;
        end else begin
            val = reg_val;
        end
        return val;
    endfunction

    // Issue, accept and redirect decisions for the current cycle.
    always_comb begin
        w_issue    = (r_state == ST_FULL) && !i_exe_busy && !r_redirect_valid;
        w_done     = i_exe_done && (w_issue || (r_state == ST_WAIT));
        // Only accept once the slot actually frees, so an issuing multi-cycle op never drops an entry.
        w_in_ready = !r_redirect_valid && ((r_state == ST_EMPTY) || w_done);
        w_accept   = w_in_ready && i_in_valid;
        w_cur_pc   = (r_state == ST_WAIT) ? r_issued.pc : r_held.pc;
        w_mispredict = w_done && (i_exe_committed_pc != (w_cur_pc + 32'd4));
        w_exe_mc   = (r_state == ST_WAIT) ? r_issued : r_held;
    end

    // Next-state selection; a pending redirect flushes whatever is held.
    always_comb begin
        w_state_nxt = r_state;
        if (r_redirect_valid) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
                ST_FULL: begin
                    if (w_issue && !w_done) begin
                        w_state_nxt = ST_WAIT;
                    end else if (w_done) begin
                        w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held and issued entry registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_held   <= '0;
            r_issued <= '0;
        end else begin
            if (w_issue) begin
                r_issued <= r_held;
            end
            if (w_accept) begin
                r_held <= i_in_microcode;
            end
        end
    end

    // Register file; x0 is never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs[0] <= {XLEN{1'b0}};
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= REG_RST;
            end
        end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Redirect pulse and target, raised the cycle after a wrong-path completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= {XLEN{1'b0}};
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= i_exe_committed_pc;
            end
        end
    end

    assign o_in_ready       = w_in_ready;
    assign o_exe_en         = w_issue;
    assign o_exe_microcode  = w_exe_mc;
    assign o_exe_rs1_data   = read_operand(w_exe_mc.rs1_addr, i_wb_en, i_wb_addr, i_wb_data,
                                           r_regs[w_exe_mc.rs1_addr]);
    assign o_exe_rs2_data   = read_operand(w_exe_mc.rs2_addr, i_wb_en, i_wb_addr, i_wb_data,
                                           r_regs[w_exe_mc.rs2_addr]);
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus randomized
// traffic checked against a transaction-level model of the slot and register file.
module tb_issue_stage;
    import issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    microcode_t  in_mc;
    logic        exe_en;
    microcode_t  exe_mc;
    logic [31:0] exe_rs1;
    logic [31:0] exe_rs2;
    logic        exe_busy;
    logic        exe_done;
    logic [31:0] exe_cpc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    issue_stage dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_in_valid         (in_valid),
        .o_in_ready         (in_ready),
        .i_in_microcode     (in_mc),
        .o_exe_en           (exe_en),
        .o_exe_microcode    (exe_mc),
        .o_exe_rs1_data     (exe_rs1),
        .o_exe_rs2_data     (exe_rs2),
        .i_exe_busy         (exe_busy),
        .i_exe_done         (exe_done),
        .i_exe_committed_pc (exe_cpc),
        .i_wb_en            (wb_en),
        .i_wb_addr          (wb_addr),
        .i_wb_data          (wb_data),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_pc      (redirect_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one decode slot, one in-flight instruction, pending redirect, registers.
    logic [31:0] m_regs [32];
    bit          m_held_v;
    bit          m_inflight;
    bit          m_redir;
    logic [31:0] m_redir_pc;
    microcode_t  m_held;
    microcode_t  m_cur;

    // Values sampled from the DUT in the most recent cycle, for directed constant checks.
    logic        s_en;
    logic        s_ready;
    logic        s_redir;
    logic [31:0] s_rpc;
    logic [31:0] s_rs1;
    logic [31:0] s_rs2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    function automatic microcode_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input bit lsu);
        microcode_t m;
        m          = '0;
        m.pc       = pc;
        m.rs1_addr = rs1;
        m.rs2_addr = rs2;
        m.rd       = 5'd1;
        m.rd_en    = 1'b1;
        m.alu_en   = !lsu;
        m.lsu_en   = lsu;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_held_v   = 1'b0;
        m_inflight = 1'b0;
        m_redir    = 1'b0;
        m_redir_pc = 32'h0;
        m_held     = '0;
        m_cur      = '0;
    endtask

    task automatic do_reset(input int n, input bit busy);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_mc    = '0;
        exe_busy = busy;
        exe_done = 1'b0;
        exe_cpc  = 32'h0;
        wb_en    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'h0;
        repeat (n) @(posedge clk);
        model_reset();
    endtask

    // One clock: drive at negedge, compare shortly after, advance the model at posedge.
    task automatic cycle(input bit v, input microcode_t mc, input bit busy, input bit done,
                         input logic [31:0] cpc, input bit we, input logic [4:0] wa,
                         input logic [31:0] wd);
        bit          e_issue, e_done, e_ready, e_mcv, n_redir;
        microcode_t  e_mc;
        logic [31:0] pc_iss;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = v;
        in_mc    = mc;
        exe_busy = busy;
        exe_done = done;
        exe_cpc  = cpc;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        e_issue = m_held_v && !m_inflight && !busy && !m_redir;
        e_done  = done && (e_issue || m_inflight);
        e_ready = !m_redir && ((!m_held_v && !m_inflight) || e_done);
        e_mcv   = m_held_v || m_inflight;
        e_mc    = m_inflight ? m_cur : m_held;
        #1;
        s_en = exe_en; s_ready = in_ready; s_redir = redirect_valid;
        s_rpc = redirect_pc; s_rs1 = exe_rs1; s_rs2 = exe_rs2;
        check("exe_en", 64'(exe_en), 64'(e_issue));
        check("in_ready", 64'(in_ready), 64'(e_ready));
        check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
        if (m_redir) check("redirect_pc", 64'(redirect_pc), 64'(m_redir_pc));
        if (e_mcv) begin
            check("exe_microcode", 64'(exe_mc), 64'(e_mc));
            check("rs1_data", 64'(exe_rs1), 64'(ref_read(e_mc.rs1_addr, we, wa, wd)));
            check("rs2_data", 64'(exe_rs2), 64'(ref_read(e_mc.rs2_addr, we, wa, wd)));
        end
        @(posedge clk);
        pc_iss  = m_inflight ? m_cur.pc : m_held.pc;
        n_redir = e_done && (cpc != pc_iss + 32'd4);
        if (n_redir) m_redir_pc = cpc;
        if (m_redir) begin
            m_held_v = 1'b0;
        end else begin
            if (e_issue) begin
                m_cur      = m_held;
                m_held_v   = 1'b0;
                m_inflight = !done;
            end else if (e_done) begin
                m_inflight = 1'b0;
            end
            if (e_ready && v) begin
                m_held   = mc;
                m_held_v = 1'b1;
            end
        end
        m_redir = n_redir;
        if (we && (wa != 5'd0)) m_regs[wa] = wd;
    endtask

    task automatic idle(input bit busy, input bit done, input logic [31:0] cpc);
        cycle(1'b0, '0, busy, done, cpc, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b1, wa, wd);
    endtask

    initial begin
        int          lat;
        bit          v, busy, done, we, iss;
        microcode_t  mc;
        logic [31:0] base, cpc;

        // Reset: idle outputs and x7 reads 0.
        do_reset(2, 1'b0);
        idle(1'b0, 1'b0, 32'h0);
        check("rst_in_ready", 64'(s_ready), 64'd1);
        check("rst_exe_en", 64'(s_en), 64'd0);
        check("rst_redirect", 64'(s_redir), 64'd0);
        cycle(1'b1, mk(32'h40, 5'd7, 5'd7, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        check("rst_x7", 64'(s_rs1), 64'd0);
        idle(1'b0, 1'b1, 32'h44);

        // Back-to-back single-cycle ops.
        cycle(1'b1, mk(32'h0, 5'd1, 5'd2, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, mk(32'h4, 5'd3, 5'd4, 1'b0), 1'b0, 1'b1, 32'h4, 1'b0, 5'd0, 32'h0);
        check("b2b_en0", 64'(s_en), 64'd1);
        cycle(1'b1, mk(32'h8, 5'd5, 5'd6, 1'b0), 1'b0, 1'b1, 32'h8, 1'b0, 5'd0, 32'h0);
        check("b2b_en1", 64'(s_en), 64'd1);
        idle(1'b0, 1'b1, 32'hC);
        check("b2b_en2", 64'(s_en), 64'd1);
        idle(1'b0, 1'b0, 32'h0);
        check("b2b_no_redirect", 64'(s_redir), 64'd0);

        // Load stall: one pulse, stable operand, ready only on the done cycle.
        wb(5'd3, 32'h0000_1234);
        cycle(1'b1, mk(32'h20, 5'd3, 5'd0, 1'b1), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        check("lw_issue_en", 64'(s_en), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0, 32'h0);
            check("lw_stall_en", 64'(s_en), 64'd0);
            check("lw_stall_ready", 64'(s_ready), 64'd0);
            check("lw_stall_rs1", 64'(s_rs1), 64'h1234);
        end
        cycle(1'b1, mk(32'h24, 5'd3, 5'd3, 1'b0), 1'b0, 1'b1, 32'h24, 1'b0, 5'd0, 32'h0);
        check("lw_done_ready", 64'(s_ready), 64'd1);
        idle(1'b0, 1'b1, 32'h28);
        check("lw_next_issue", 64'(s_en), 64'd1);

        // Bypass and x0.
        cycle(1'b1, mk(32'h30, 5'd5, 5'd0, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        wb(5'd5, 32'hDEAD_BEEF);
        check("bypass_rs1", 64'(s_rs1), 64'hDEAD_BEEF);
        wb(5'd0, 32'hFFFF_FFFF);
        check("x0_bypass_rs2", 64'(s_rs2), 64'd0);
        idle(1'b1, 1'b0, 32'h0);
        check("x0_read_rs2", 64'(s_rs2), 64'd0);
        check("reg_rs1", 64'(s_rs1), 64'hDEAD_BEEF);
        idle(1'b0, 1'b1, 32'h34);

        // Redirect flushes the wrong-path entry.
        cycle(1'b1, mk(32'h100, 5'd1, 5'd2, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, mk(32'h104, 5'd1, 5'd2, 1'b0), 1'b0, 1'b1, 32'h200, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, mk(32'h300, 5'd1, 5'd2, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("redir_valid", 64'(s_redir), 64'd1);
        check("redir_pc", 64'(s_rpc), 64'h200);
        check("redir_no_en", 64'(s_en), 64'd0);
        check("redir_no_ready", 64'(s_ready), 64'd0);
        idle(1'b0, 1'b0, 32'h0);
        check("flushed_no_en", 64'(s_en), 64'd0);
        check("redir_pulse_end", 64'(s_redir), 64'd0);

        // PC wrap: 0xFFFFFFFC + 4 = 0 is sequential.
        cycle(1'b1, mk(32'hFFFF_FFFC, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(1'b0, 1'b1, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        check("wrap_no_redirect", 64'(s_redir), 64'd0);

        // Reset while a load is outstanding.
        cycle(1'b1, mk(32'h50, 5'd1, 5'd1, 1'b1), 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        do_reset(1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0, 32'h0);
            check("midwait_rst_en", 64'(s_en), 64'd0);
        end

        // Randomized traffic with a small execute responder.
        lat = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 2)), bit'($urandom_range(0, 1)));
                continue;
            end
            v  = ($urandom_range(0, 3) != 0);
            mc = mk($urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 3));
            we = bit'($urandom_range(0, 1));
            if (m_inflight) begin
                if (lat > 0) begin
                    busy = 1'b1; done = 1'b0; lat--;
                end else begin
                    busy = 1'b0; done = 1'b1;
                end
            end else begin
                busy = ($urandom_range(0, 4) == 0);
                iss  = m_held_v && !busy && !m_redir;
                done = iss && !m_held.lsu_en;
                if (iss && m_held.lsu_en) lat = int'($urandom_range(0, 2));
            end
            base = m_inflight ? m_cur.pc : m_held.pc;
            cpc  = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : base + 32'd4;
            cycle(v, mc, busy, done, cpc, we, 5'($urandom_range(0, 31)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
